// File: rtl/mac_pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_pipe_sequencer
// Purpose  : Issues one dot-product job through a multiply->add pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mac_pipe_sequencer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             src_valid_i,
    output logic             src_rd_o,
    output logic [CNT_W-1:0] op_idx_o,
    output logic             ld_mult_o,
    output logic             ld_add_o,
    output logic             acc_clr_o,
    output logic             pipe_stall_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] op_idx_q, op_idx_d;
    logic             v_mult_q, v_mult_d;
    logic             w_last_pop;

    // len_q is never zero in RUN, so len_q-1 cannot underflow here.
    assign w_last_pop = (op_idx_q == (len_q - c_CNT_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= c_CNT_ZERO;
            op_idx_q <= c_CNT_ZERO;
            v_mult_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            op_idx_q <= op_idx_d;
            v_mult_q <= v_mult_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        op_idx_d     = op_idx_q;
        src_rd_o     = 1'b0;
        ld_mult_o    = 1'b0;
        ld_add_o     = v_mult_q;
        acc_clr_o    = 1'b0;
        pipe_stall_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        op_idx_o     = op_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_clr_o = 1'b1;
                    len_d     = len_i;
                    op_idx_d  = c_CNT_ZERO;
                    state_d   = (len_i != c_CNT_ZERO) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (src_valid_i) begin
                    src_rd_o  = 1'b1;
                    ld_mult_o = 1'b1;
                    op_idx_d  = op_idx_q + c_CNT_ONE;
                    if (w_last_pop) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    pipe_stall_o = 1'b1;
                end
                // A pop coinciding with abort still happens; its product is dropped below.
                if (abort_i) begin
                    state_d  = S_IDLE;
                    op_idx_d = c_CNT_ZERO;
                end
            end
            S_DRAIN: begin
                busy_o  = 1'b1;
                state_d = S_DONE;
                if (abort_i) begin
                    state_d  = S_IDLE;
                    op_idx_d = c_CNT_ZERO;
                end
            end
            S_DONE: begin
                done_o   = 1'b1;
                state_d  = S_IDLE;
                op_idx_d = c_CNT_ZERO;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        v_mult_d = ld_mult_o & ~abort_i;
    end

endmodule
`default_nettype wire
